mult_sched: RTL

//   Shares one combinational 8x8 unsigned array multiplier (mult) among NREQ requesters.

---
 rtl/mult_sched_pkg.sv | 29 ++
 rtl/mult.sv | 27 ++
 rtl/rr_arbiter.sv | 21 ++
 rtl/mult_sched.sv | 111 +++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types, default sizes and the round-robin pick function for the
// multiplier scheduler.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;

  // First set bit of valid scanning ptr+1, ptr+2, ... modulo n (n <= 32).
  function automatic int rr_pick(input logic [31:0] valid, input int ptr, input int n);
    int pick;
    bit found;
    pick  = 0;
    found = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      if (k <= n && !found && valid[5'((ptr + k) % n)]) begin
        pick  = (ptr + k) % n;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mult.sv
// Combinational unsigned array multiplier: one shifted partial product per
// bit of D2, summed in a ripple chain.
module mult #(
  parameter int W = 8
) (
  input  logic [W-1:0]   D1,
  input  logic [W-1:0]   D2,
  output logic [2*W-1:0] out
);

  logic [W-1:0][2*W-1:0] w_pp;
  logic [2*W-1:0]        w_sum;

  for (genvar gi = 0; gi < W; gi++) begin : g_row
    assign w_pp[gi] = {{W{1'b0}}, D1 & {W{D2[gi]}}} << gi;
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < W; i++) begin
      w_sum = w_sum + w_pp[i];
    end
  end

  assign out = w_sum;

endmodule

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin pick: the first valid requester after
// the last-granted index wins.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDW-1:0]  i_ptr,
  output logic [IDW-1:0]  o_grant,
  output logic            o_any_valid
);

  logic [31:0] w_valid_ext;

  assign w_valid_ext = 32'(i_valid);
  assign o_grant     = IDW'(rr_pick(w_valid_ext, int'(i_ptr), NREQ));
  assign o_any_valid = |i_valid;

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one combinational multiplier among NREQ
// requesters; operands are held MULT_CYCLES cycles before the product is captured.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter  int NREQ        = NREQ_DEF,
  parameter  int W           = W_DEF,
  parameter  int MULT_CYCLES = 2,
  localparam int IDW         = $clog2(NREQ),
  localparam int CW          = $clog2(MULT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_data,
  output logic              busy
);

  state_t          r_state, w_state_next;
  logic [IDW-1:0]  r_rr_ptr, r_op_id, r_rsp_id, w_grant;
  logic [W-1:0]    r_op_a, r_op_b, w_sel_a, w_sel_b;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_rsp_data, w_product;
  logic            r_rsp_valid, w_any_valid;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_valid     (req_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_any_valid (w_any_valid)
  );

  mult #(.W(W)) u_mult (
    .D1  (r_op_a),
    .D2  (r_op_b),
    .out (w_product)
  );

  assign w_sel_a = req_a[int'(w_grant)*W +: W];
  assign w_sel_b = req_b[int'(w_grant)*W +: W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    case (r_state)
      IDLE: begin
        if (w_any_valid) begin
          req_ready[w_grant] = 1'b1;
          w_state_next       = CALC;
        end
      end
      CALC:    if (r_cnt == '0) w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= IDW'(NREQ - 1);
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_id     <= '0;
      r_cnt       <= '0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_op_a   <= w_sel_a;
            r_op_b   <= w_sel_b;
            r_op_id  <= w_grant;
            r_rr_ptr <= w_grant;
            r_cnt    <= CW'(MULT_CYCLES - 1);
          end
        end
        CALC: begin
          // The array has had MULT_CYCLES cycles to settle once cnt reaches zero.
          if (r_cnt == '0) begin
            r_rsp_data  <= w_product;
            r_rsp_id    <= r_op_id;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        RESP:    if (rsp_ready) r_rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != IDLE);

endmodule
